// File: rtl/y_mux4to1_if.sv
// Bundle of the 4:1 mux data signals, for benches and wrappers that want to
// carry the select path as one object. The mux itself keeps plain ports so
// existing positional instantiations still connect.
interface y_mux4to1_if #(
  parameter int unsigned SIZE = 32
);
  logic [SIZE-1:0] a0;
  logic [SIZE-1:0] a1;
  logic [SIZE-1:0] a2;
  logic [SIZE-1:0] a3;
  logic [1:0]      c;
  logic [SIZE-1:0] z;
  logic [SIZE-1:0] z_q;

  // Driver side: supplies data words and select, observes both outputs.
  modport master (
    output a0, a1, a2, a3, c,
    input  z, z_q
  );

  // Mux side: consumes data words and select, produces both outputs.
  modport slave (
    input  a0, a1, a2, a3, c,
    output z, z_q
  );
endinterface

// File: rtl/y_mux4to1_mux2.sv
// SIZE-wide 2:1 mux built from independent per-bit selects.
// An unknown select merges agreeing bits and leaves differing bits X.
module y_mux2to1 #(
  parameter int unsigned SIZE = 32
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c
);

  // Per-bit select: b when c is high, a when c is low.
  always_comb begin
    z = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      z[i] = c ? b[i] : a[i];
    end
  end

endmodule

// File: rtl/y_mux4to1.sv
// Parameterised 4:1 word mux with a combinational output z and a
// registered copy z_q. Built as a tree of three 2:1 muxes.
module y_mux4to1 #(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  output logic [SIZE-1:0] z_q
);

  logic [SIZE-1:0] lo;
  logic [SIZE-1:0] hi;

  y_mux2to1 #(.SIZE(SIZE)) u_lo (
    .z (lo),
    .a (a0),
    .b (a1),
    .c (c[0])
  );

  y_mux2to1 #(.SIZE(SIZE)) u_hi (
    .z (hi),
    .a (a2),
    .b (a3),
    .c (c[0])
  );

  y_mux2to1 #(.SIZE(SIZE)) u_out (
    .z (z),
    .a (lo),
    .b (hi),
    .c (c[1])
  );

  // Registered copy of the selected word; reset clears it, z is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= '0;
    end else begin
      z_q <= z;
    end
  end

endmodule

// File: tb/tb_y_mux4to1.sv
// Self-checking bench for y_mux4to1: directed select patterns, bit
// independence at widths 32/8/1, register/reset timing and random vectors
// against a table-lookup reference model.
module tb_y_mux4to1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  y_mux4to1_if #(.SIZE(32)) bus ();

  logic [7:0] z8;
  logic [7:0] z8_q;
  logic [0:0] z1;
  logic [0:0] z1_q;

  y_mux4to1 #(.SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .z   (bus.z),
    .a0  (bus.a0),
    .a1  (bus.a1),
    .a2  (bus.a2),
    .a3  (bus.a3),
    .c   (bus.c),
    .z_q (bus.z_q)
  );

  y_mux4to1 #(.SIZE(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .z   (z8),
    .a0  (bus.a0[7:0]),
    .a1  (bus.a1[7:0]),
    .a2  (bus.a2[7:0]),
    .a3  (bus.a3[7:0]),
    .c   (bus.c),
    .z_q (z8_q)
  );

  y_mux4to1 #(.SIZE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .z   (z1),
    .a0  (bus.a0[0:0]),
    .a1  (bus.a1[0:0]),
    .a2  (bus.a2[0:0]),
    .a3  (bus.a3[0:0]),
    .c   (bus.c),
    .z_q (z1_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the selected word is simply the c-th entry of a table.
  logic [31:0] words [4];

  function automatic logic [31:0] ref_sel(input logic [1:0] sel);
    return words[sel];
  endfunction

  task automatic drive(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input logic [1:0] sel);
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    bus.a0 = w0; bus.a1 = w1; bus.a2 = w2; bus.a3 = w3;
    bus.c  = sel;
  endtask

  logic [31:0] exp_w;
  logic [31:0] held;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive('0, '0, '0, '0, 2'b00);

    // Reset clears all three registered copies.
    @(negedge clk);
    @(posedge clk); #1;
    check("rst_zq32", bus.z_q, 32'h0);
    check("rst_zq8", {24'h0, z8_q}, 32'h0);
    check("rst_zq1", {31'h0, z1_q}, 32'h0);

    // Each select value with fixed words.
    for (int s = 0; s < 4; s++) begin
      drive(32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663, 2'(s));
      #1;
      check($sformatf("sel%0d", s), bus.z, ref_sel(2'(s)));
    end

    // Bit independence at 32, 8 and 1 bits.
    for (int s = 0; s < 4; s++) begin
      drive(32'h00000000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555, 2'(s));
      #1;
      exp_w = ref_sel(2'(s));
      check($sformatf("bits32_c%0d", s), bus.z, exp_w);
      check($sformatf("bits8_c%0d", s), {24'h0, z8}, {24'h0, exp_w[7:0]});
      check($sformatf("bits1_c%0d", s), {31'h0, z1}, {31'h0, exp_w[0]});
    end

    // Register path: load after reset release.
    @(negedge clk);
    rst = 1'b0;
    drive(32'h11111111, 32'h22222222, 32'hDEADBEEF, 32'h44444444, 2'b10);
    @(posedge clk); #1;
    check("zq_load", bus.z_q, 32'hDEADBEEF);
    check("zq8_load", {24'h0, z8_q}, 32'h000000EF);

    // Select change between edges: z moves at once, z_q waits for the edge.
    bus.c = 2'b01;
    #1;
    check("z_immediate", bus.z, 32'h22222222);
    check("zq_hold", bus.z_q, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("zq_next_edge", bus.z_q, 32'h22222222);

    // Reset mid-stream: z_q clears for one edge, z keeps the selection.
    @(negedge clk);
    bus.c = 2'b10;
    @(posedge clk); #1;
    check("zq_pre_rst", bus.z_q, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("zq_mid_rst", bus.z_q, 32'h0);
    check("z_during_rst", bus.z, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("zq_reload", bus.z_q, 32'hDEADBEEF);

    // Unknown select bit over agreeing candidates resolves to the shared value.
    @(negedge clk);
    drive(32'h0F0F0F0F, 32'h12345678, 32'h0F0F0F0F, 32'h9ABCDEF0, 2'b00);
    bus.c = 2'bx0;
    #1;
    check("x_sel_agree", bus.z, 32'h0F0F0F0F);

    // Random regression on both z and the one-cycle-late z_q.
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      drive($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
      held = ref_sel(bus.c);
      #1;
      check($sformatf("rand_z_%0d", n), bus.z, held);
      check($sformatf("rand_z8_%0d", n), {24'h0, z8}, {24'h0, held[7:0]});
      @(posedge clk); #1;
      check($sformatf("rand_zq_%0d", n), bus.z_q, held);
      check($sformatf("rand_zq1_%0d", n), {31'h0, z1_q}, {31'h0, held[0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y_mux4to1.md
Name: y_mux4to1

Overview:
- Parameterised 4-to-1 word multiplexer: selects one of four SIZE-bit words using a 2-bit select.
- Combinational output z is valid in the same time step as input changes.
- Registered copy z_q is provided for use on the single system clock.
- Used as the 4-way selection primitive in datapaths, e.g. ALU result select and PC-source select.

Parameters:
- SIZE, 32, width in bits of each data input and of both outputs (legal: SIZE >= 1).

Ports:
- clk  input  1  system clock; z_q updates on the rising edge.
- rst  input  1  synchronous, active-high reset; affects z_q only.
- z  output  SIZE  combinational selected word.
- a0  input  SIZE  data input, selected when c = 2'b00.
- a1  input  SIZE  data input, selected when c = 2'b01.
- a2  input  SIZE  data input, selected when c = 2'b10.
- a3  input  SIZE  data input, selected when c = 2'b11.
- c  input  2  select.
- z_q  output  SIZE  registered copy of z.
- Interface is fixed: one clock (clk); reset rst is synchronous and active-high.
- Positional order after clk, rst is z, a0, a1, a2, a3, c, z_q. Existing instantiations connect z, a0..a3, c in that order.

Behaviour:
- z = a0 / a1 / a2 / a3 for c = 00 / 01 / 10 / 11.
- z is purely combinational: no clock involvement, no latch, zero clock latency. z settles within one simulation time unit of any input change.
- Every bit is selected independently: z[i] = a_c[i] for all i in 0..SIZE-1. No bit reordering, no sign or zero extension.
- c containing X or Z: z bits where the candidate inputs agree take that value; other bits are X. This is natural gate-level 2:1-tree behaviour; no X-masking to 0.
- z is independent of clk and rst. Reset does not force z.
- z_q: on each rising clk edge, if rst = 1 then z_q <= 0 (all SIZE bits). Otherwise z_q <= z, i.e. the value selected by c and a0..a3 just before the edge.
- z_q has one-cycle latency and holds between edges.
- Reset asserted mid-operation clears z_q at the next edge only. Deasserting rst lets z_q load z at the following edge.
- Before the first clock edge z_q is X. Benches must apply reset before checking z_q.
- No handshake, no enable, no internal state other than the z_q register.

Decomposition:
- No shared package needed. The only constant is the default width 32, which stays a module parameter.
- Natural sub-module: y_mux2to1, a SIZE-wide 2:1 mux with output z, inputs a, b, c (a selected when c = 0), built from per-bit 1-bit muxes.
- y_mux4to1 instantiates three y_mux2to1:
  - lo = c[0] ? a1 : a0
  - hi = c[0] ? a3 : a2
  - z = c[1] ? hi : lo
- The z_q register is a single always-block on clk with synchronous rst.

Test Plan:
- Each select value: a0=32'h12153524, a1=32'hC0895E81, a2=32'h8484D609, a3=32'hB1F05663; c = 00, 01, 10, 11 -> z equals a0, a1, a2, a3 respectively, checked with === after #1.
- Random regression: 10+ iterations of $random a0..a3 and c -> z === a[c] after #1 every time; print PASS/FAIL per vector.
- Bit independence: a0=0, a1=32'hFFFFFFFF, a2=32'hAAAAAAAA, a3=32'h55555555; sweep c -> exact patterns, no bit crosstalk. Repeat with SIZE=1 and SIZE=8 instances.
- Register path: rst=1 for one edge -> z_q = 0. With rst=0, c=10 and a2=32'hDEADBEEF, one edge later z_q = 32'hDEADBEEF. Changing c between edges changes z immediately and z_q only at the next edge.
- Reset mid-stream: with z_q = 32'hDEADBEEF, assert rst for one edge -> z_q = 0 while z still shows the selected input. Deassert rst -> the next edge reloads z.
- Unknown select: c=2'bx0, a0 = a2 = 32'h0F0F0F0F -> z = 32'h0F0F0F0F. With a0 != a2, the differing bits of z are X.
